// File: rtl/jtgng_romload_pkg.sv
// jtgng_romload_pkg: shared widths and arbiter state encoding for the ROM download arbiter
package jtgng_romload_pkg;
    localparam int DEF_AW    = 22;
    localparam int DEF_RD_TO = 255;
    localparam int TW        = 8;
    typedef enum logic [1:0] {IDLE, WR, RD} state_t;
endpackage

// File: rtl/jtgng_romload_pack.sv
// jtgng_romload_pack: packs download bytes into masked 16-bit words behind a one-entry write buffer
module jtgng_romload_pack
    import jtgng_romload_pkg::*;
#(
    parameter int AW = DEF_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          dl_active,
    input  logic          dl_wr,
    input  logic [AW-1:0] dl_addr,
    input  logic [7:0]    dl_data,
    input  logic          wb_free,
    output logic          wb_valid,
    output logic [AW-2:0] wb_addr,
    output logic [15:0]   wb_data,
    output logic [1:0]    wb_be,
    output logic          dl_ovf
);
    logic          act_q, act_d;
    logic          lo_valid_q, lo_valid_d;
    logic [AW-2:0] lo_addr_q, lo_addr_d;
    logic [7:0]    lo_data_q, lo_data_d;
    logic          hi_pend_q, hi_pend_d;
    logic [AW-2:0] hi_addr_q, hi_addr_d;
    logic [7:0]    hi_data_q, hi_data_d;
    logic          wb_valid_q, wb_valid_d;
    logic [AW-2:0] wb_addr_q, wb_addr_d;
    logic [15:0]   wb_data_q, wb_data_d;
    logic [1:0]    wb_be_q, wb_be_d;
    logic          ovf_q, ovf_d;
    logic          push;
    logic [AW-2:0] p_addr;
    logic [15:0]   p_data;
    logic [1:0]    p_be;
    logic [AW-2:0] waddr;
    logic          wb_open;

    assign waddr   = dl_addr[AW-1:1];
    assign wb_open = !wb_valid_q || wb_free;

    // Byte placement: a deferred odd byte goes first, then the incoming byte, then a lone-byte flush once idle
    always_comb begin
        act_d      = dl_active;
        lo_valid_d = lo_valid_q;
        lo_addr_d  = lo_addr_q;
        lo_data_d  = lo_data_q;
        hi_pend_d  = hi_pend_q;
        hi_addr_d  = hi_addr_q;
        hi_data_d  = hi_data_q;
        ovf_d      = (dl_active && !act_q) ? 1'b0 : ovf_q;
        push       = 1'b0;
        p_addr     = lo_addr_q;
        p_data     = {8'h00, lo_data_q};
        p_be       = 2'b01;
        if (hi_pend_q && wb_open) begin
            push      = 1'b1;
            p_addr    = hi_addr_q;
            p_data    = {hi_data_q, 8'h00};
            p_be      = 2'b10;
            hi_pend_d = 1'b0;
        end
        if (dl_wr && !dl_addr[0]) begin
            lo_valid_d = 1'b1;
            lo_addr_d  = waddr;
            lo_data_d  = dl_data;
        end else if (dl_wr) begin
            if (!wb_open || hi_pend_q) begin
                ovf_d = 1'b1;
            end else if (lo_valid_q && lo_addr_q != waddr) begin
                push       = 1'b1;
                lo_valid_d = 1'b0;
                hi_pend_d  = 1'b1;
                hi_addr_d  = waddr;
                hi_data_d  = dl_data;
            end else begin
                push       = 1'b1;
                p_addr     = waddr;
                p_data     = {dl_data, lo_data_q};
                p_be       = {1'b1, lo_valid_q};
                lo_valid_d = 1'b0;
            end
        end else if (lo_valid_q && !dl_active && wb_open && !hi_pend_q) begin
            push       = 1'b1;
            lo_valid_d = 1'b0;
        end
        wb_valid_d = push ? 1'b1 : (wb_valid_q && !wb_free);
        wb_addr_d  = push ? p_addr : wb_addr_q;
        wb_data_d  = push ? p_data : wb_data_q;
        wb_be_d    = push ? p_be : wb_be_q;
    end

    // Packer and write-buffer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_q      <= 1'b0;
            lo_valid_q <= 1'b0;
            lo_addr_q  <= '0;
            lo_data_q  <= '0;
            hi_pend_q  <= 1'b0;
            hi_addr_q  <= '0;
            hi_data_q  <= '0;
            wb_valid_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            wb_be_q    <= '0;
            ovf_q      <= 1'b0;
        end else begin
            act_q      <= act_d;
            lo_valid_q <= lo_valid_d;
            lo_addr_q  <= lo_addr_d;
            lo_data_q  <= lo_data_d;
            hi_pend_q  <= hi_pend_d;
            hi_addr_q  <= hi_addr_d;
            hi_data_q  <= hi_data_d;
            wb_valid_q <= wb_valid_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
            wb_be_q    <= wb_be_d;
            ovf_q      <= ovf_d;
        end
    end

    assign wb_valid = wb_valid_q;
    assign wb_addr  = wb_addr_q;
    assign wb_data  = wb_data_q;
    assign wb_be    = wb_be_q;
    assign dl_ovf   = ovf_q;
endmodule

// File: rtl/jtgng_romload_arb.sv
// jtgng_romload_arb: shares one memory port between the download byte stream and game ROM reads
module jtgng_romload_arb
    import jtgng_romload_pkg::*;
#(
    parameter int AW    = DEF_AW,
    parameter int RD_TO = DEF_RD_TO
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          dl_active,
    input  logic          dl_wr,
    input  logic [AW-1:0] dl_addr,
    input  logic [7:0]    dl_data,
    output logic          dl_ovf,
    input  logic          rd_req,
    input  logic [AW-2:0] rd_addr,
    output logic [15:0]   rd_data,
    output logic          rd_ok,
    output logic          rd_err,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-2:0] mem_addr,
    output logic [15:0]   mem_din,
    output logic [1:0]    mem_be,
    input  logic [15:0]   mem_dout,
    input  logic          mem_ack
);
    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          rd_done_q, rd_done_d;
    logic [15:0]   rd_data_q, rd_data_d;
    logic          rd_ok_q, rd_ok_d;
    logic          rd_err_q, rd_err_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-2:0] mem_addr_q, mem_addr_d;
    logic [15:0]   mem_din_q, mem_din_d;
    logic [1:0]    mem_be_q, mem_be_d;
    logic          wb_valid, wb_free;
    logic [AW-2:0] wb_addr;
    logic [15:0]   wb_data;
    logic [1:0]    wb_be;

    jtgng_romload_pack #(.AW(AW)) u_pack (
        .clk       (clk),
        .rst_n     (rst_n),
        .dl_active (dl_active),
        .dl_wr     (dl_wr),
        .dl_addr   (dl_addr),
        .dl_data   (dl_data),
        .wb_free   (wb_free),
        .wb_valid  (wb_valid),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .wb_be     (wb_be),
        .dl_ovf    (dl_ovf)
    );

    // One request in flight; buffered writes beat reads, reads wait out downloads and need rd_req re-armed
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        rd_done_d  = rd_req && rd_done_q;
        rd_data_d  = rd_data_q;
        rd_ok_d    = 1'b0;
        rd_err_d   = 1'b0;
        mem_req_d  = mem_req_q;
        mem_we_d   = mem_we_q;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        mem_be_d   = mem_be_q;
        wb_free    = 1'b0;
        case (state_q)
            IDLE: begin
                if (wb_valid) begin
                    state_d    = WR;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b1;
                    mem_addr_d = wb_addr;
                    mem_din_d  = wb_data;
                    mem_be_d   = wb_be;
                end else if (rd_req && !dl_active && !rd_done_q) begin
                    state_d    = RD;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = rd_addr;
                    mem_be_d   = 2'b11;
                    timer_d    = '0;
                end
            end
            WR: begin
                if (mem_ack) begin
                    wb_free   = 1'b1;
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                end
            end
            RD: begin
                if (mem_ack || timer_q == TW'(RD_TO - 1)) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    rd_done_d = 1'b1;
                    rd_ok_d   = mem_ack;
                    rd_err_d  = !mem_ack;
                    rd_data_d = mem_ack ? mem_dout : rd_data_q;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Arbiter state and registered memory/read-port outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            rd_done_q  <= 1'b0;
            rd_data_q  <= '0;
            rd_ok_q    <= 1'b0;
            rd_err_q   <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            mem_be_q   <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            rd_done_q  <= rd_done_d;
            rd_data_q  <= rd_data_d;
            rd_ok_q    <= rd_ok_d;
            rd_err_q   <= rd_err_d;
            mem_req_q  <= mem_req_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            mem_be_q   <= mem_be_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_ok    = rd_ok_q;
    assign rd_err   = rd_err_q;
    assign mem_req  = mem_req_q;
    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;
    assign mem_be   = mem_be_q;
endmodule

// File: tb/tb_jtgng_romload_arb.sv
// tb_jtgng_romload_arb: scoreboard bench for the ROM download / game read arbiter
module tb_jtgng_romload_arb;
    typedef struct {
        logic        we;
        logic [20:0] addr;
        logic [15:0] din;
        logic [15:0] mask;
        logic [1:0]  be;
    } mem_t;
    typedef struct {
        logic        err;
        logic [15:0] data;
    } rsp_t;

    logic        clk, rst_n;
    logic        dl_active, dl_wr;
    logic [21:0] dl_addr;
    logic [7:0]  dl_data;
    logic        dl_ovf;
    logic        rd_req;
    logic [20:0] rd_addr;
    logic [15:0] rd_data;
    logic        rd_ok, rd_err;
    logic        mem_req, mem_we;
    logic [20:0] mem_addr;
    logic [15:0] mem_din;
    logic [1:0]  mem_be;
    logic [15:0] mem_dout;
    logic        mem_ack;

    mem_t exp_mem[$];
    rsp_t exp_rd[$];
    int   errors = 0;
    int   checks = 0;
    int   req_cycles = 0;
    int   req_starts = 0;
    int   wait_n = 0;
    int   ack_dly = 1;
    logic ack_en = 1'b1;
    logic seen = 1'b0;
    logic [15:0] rd_val = 16'h0000;

    jtgng_romload_arb dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .dl_active (dl_active),
        .dl_wr     (dl_wr),
        .dl_addr   (dl_addr),
        .dl_data   (dl_data),
        .dl_ovf    (dl_ovf),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_ok     (rd_ok),
        .rd_err    (rd_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_be    (mem_be),
        .mem_dout  (mem_dout),
        .mem_ack   (mem_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic exp_wr(input logic [20:0] a, input logic [15:0] d, input logic [15:0] m, input logic [1:0] be);
        mem_t t;
        t.we = 1'b1; t.addr = a; t.din = d; t.mask = m; t.be = be;
        exp_mem.push_back(t);
    endtask

    task automatic exp_read(input logic [20:0] a, input logic err, input logic [15:0] d);
        mem_t t;
        rsp_t r;
        t.we = 1'b0; t.addr = a; t.din = 16'h0; t.mask = 16'h0; t.be = 2'b11;
        r.err = err; r.data = d;
        exp_mem.push_back(t);
        exp_rd.push_back(r);
    endtask

    task automatic send(input logic [21:0] a, input logic [7:0] d);
        @(negedge clk);
        dl_addr = a; dl_data = d; dl_wr = 1'b1;
        @(negedge clk);
        dl_wr = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_mem.size() != 0 || exp_rd.size() != 0 || mem_req) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(n < 400), 32'd1);
    endtask

    // Monitor: checks read responses and memory requests against the queues, and acts as the memory
    initial begin
        mem_t m;
        rsp_t r;
        mem_ack = 1'b0;
        mem_dout = 16'h0;
        forever begin
            @(negedge clk);
            if (rd_ok || rd_err) begin
                if (exp_rd.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_unexpected: ok=%0b err=%0b but no response expected", rd_ok, rd_err);
                end else begin
                    r = exp_rd.pop_front();
                    chk("rd_err", 32'(rd_err), 32'(r.err));
                    if (r.err) begin
                        chk("rd_to_cycles", req_cycles, 255);
                        chk("rd_to_req_drop", 32'(mem_req), 32'd0);
                    end else begin
                        chk("rd_data", 32'(rd_data), 32'(r.data));
                        chk("rd_ok_after_ack", 32'(mem_ack), 32'd1);
                    end
                end
            end
            if (mem_ack) begin
                mem_ack = 1'b0;
                seen = 1'b0;
            end else if (mem_req) begin
                if (!seen) begin
                    seen = 1'b1;
                    wait_n = 0;
                    req_cycles = 0;
                    req_starts++;
                    if (exp_mem.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL mem_unexpected: we=%0b addr=%0h din=%0h be=%0b but none expected", mem_we, mem_addr, mem_din, mem_be);
                    end else begin
                        m = exp_mem.pop_front();
                        chk("mem_we", 32'(mem_we), 32'(m.we));
                        chk("mem_addr", 32'(mem_addr), 32'(m.addr));
                        if (m.we) begin
                            chk("mem_din", 32'(mem_din & m.mask), 32'(m.din & m.mask));
                            chk("mem_be", 32'(mem_be), 32'(m.be));
                        end
                    end
                end
                req_cycles++;
                if (ack_en && wait_n >= ack_dly) begin
                    mem_ack = 1'b1;
                    mem_dout = rd_val;
                end
                wait_n++;
            end else begin
                seen = 1'b0;
            end
        end
    end

    // Directed stimulus
    initial begin
        int cyc;
        int st;
        rst_n = 1'b0; dl_active = 1'b0; dl_wr = 1'b0; dl_addr = '0; dl_data = '0;
        rd_req = 1'b0; rd_addr = '0;
        repeat (3) @(negedge clk);
        chk("reset_ctl", 32'({mem_req, mem_we, mem_be, rd_ok, rd_err, dl_ovf}), 32'd0);
        chk("reset_addr", 32'(mem_addr), 32'd0);
        chk("reset_data", 32'({mem_din, rd_data}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Even/odd pair packs into one full-word write
        dl_active = 1'b1;
        exp_wr(21'h0, 16'h8310, 16'hFFFF, 2'b11);
        send(22'h0, 8'h10);
        send(22'h1, 8'h83);
        drain("t1_drain");
        chk("t1_ovf", 32'(dl_ovf), 32'd0);

        // Lone even byte is held until the download ends
        send(22'h4, 8'hAA);
        repeat (4) @(negedge clk);
        chk("t2_lone_held", 32'(mem_req), 32'd0);
        exp_wr(21'h2, 16'h00AA, 16'h00FF, 2'b01);
        dl_active = 1'b0;
        drain("t2_drain");

        // Reads stall during a download, then complete
        dl_active = 1'b1;
        rd_addr = 21'h123;
        rd_req = 1'b1;
        repeat (6) @(negedge clk);
        chk("t3_stalled", 32'(mem_req), 32'd0);
        ack_dly = 0;
        rd_val = 16'hBEEF;
        exp_read(21'h123, 1'b0, 16'hBEEF);
        dl_active = 1'b0;
        drain("t3_drain");
        rd_req = 1'b0;
        @(negedge clk);

        // Minimum read latency, counting the rd_req rise cycle as 1
        rd_val = 16'h1234;
        exp_read(21'h0AB, 1'b0, 16'h1234);
        rd_addr = 21'h0AB;
        rd_req = 1'b1;
        cyc = 1;
        while (!rd_ok && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("t3_min_latency", cyc, 3);
        rd_req = 1'b0;
        drain("t3b_drain");

        // Overflow: second odd byte while the buffer is stuck full
        ack_en = 1'b0;
        dl_active = 1'b1;
        exp_wr(21'h08, 16'h5500, 16'hFF00, 2'b10);
        send(22'h11, 8'h55);
        send(22'h13, 8'h66);
        repeat (2) @(negedge clk);
        chk("t4_ovf_set", 32'(dl_ovf), 32'd1);
        ack_en = 1'b1;
        drain("t4_drain");
        chk("t4_ovf_sticky", 32'(dl_ovf), 32'd1);
        dl_active = 1'b0;
        repeat (3) @(negedge clk);
        chk("t4_ovf_after_fall", 32'(dl_ovf), 32'd1);
        dl_active = 1'b1;
        repeat (2) @(negedge clk);
        chk("t4_ovf_clear", 32'(dl_ovf), 32'd0);
        dl_active = 1'b0;
        @(negedge clk);

        // Read timeout and no reissue while rd_req stays high
        ack_en = 1'b0;
        exp_read(21'h055, 1'b1, 16'h0);
        rd_addr = 21'h055;
        rd_req = 1'b1;
        drain("t5_drain");
        st = req_starts;
        repeat (10) @(negedge clk);
        chk("t5_no_reissue", req_starts - st, 0);
        chk("t5_req_low", 32'(mem_req), 32'd0);
        rd_req = 1'b0;
        ack_en = 1'b1;
        @(negedge clk);

        // Asynchronous reset in the middle of a write
        ack_en = 1'b0;
        dl_active = 1'b1;
        exp_wr(21'h10, 16'h7788, 16'hFFFF, 2'b11);
        send(22'h20, 8'h88);
        send(22'h21, 8'h77);
        send(22'h23, 8'h99);
        chk("t6_pre_req", 32'(mem_req), 32'd1);
        chk("t6_pre_ovf", 32'(dl_ovf), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_outs", 32'({mem_req, rd_ok, dl_ovf}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dl_active = 1'b0;
        ack_en = 1'b1;
        repeat (5) @(negedge clk);
        chk("t6_idle_after_rst", 32'(mem_req), 32'd0);
        rd_val = 16'hC0DE;
        exp_read(21'h3FF, 1'b0, 16'hC0DE);
        rd_addr = 21'h3FF;
        rd_req = 1'b1;
        drain("t6_read_after_rst");
        rd_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("sb_empty", exp_mem.size() + exp_rd.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
